if_fetch_queue: RTL and testbench

//  Instruction fetch front end that supplies the decode stage.
//  - Generates sequential PCs and issues reads on the SRAM-like instruction bus.
//  - Buffers returned words with their PC in a small FIFO.
//  - Presents {instrD, pcD, adelD} to the decoder with a valid/ready handshake.
//  - Flushes and restarts on a branch/exception redirect.

---
 rtl/if_fetch_queue_if.sv | 26 ++
 rtl/if_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch front-end signal bundle: instruction bus, redirect and decode handshake.
// master = fetch queue side, slave = bus/decoder environment side.
interface if_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        instrD_valid;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic        adelD;
    logic        decode_ready;

    modport master (
        input  redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, decode_ready,
        output inst_req, inst_addr, instrD_valid, instrD, pcD, adelD
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, decode_ready,
        input  inst_req, inst_addr, instrD_valid, instrD, pcD, adelD
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: sequential PC generation, credit-limited bus reads,
// in-order response buffering and redirect flush with stale-response discard.
module if_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hBFC00000
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_queue_if.master   fq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned INF_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DIS_W = 8;
    localparam int unsigned SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    typedef enum logic {RUN, HALT} fetchState_t;

    fetchState_t      state;
    fetchState_t      stateNext;
    logic [31:0]      fetchPc;
    logic [31:0]      respPc;
    logic [INF_W-1:0] inflight;
    logic [DIS_W-1:0] discard;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [31:0]      memInstr [DEPTH];
    logic [31:0]      memPc    [DEPTH];
    logic             memAdel  [DEPTH];

    logic instReq;
    logic accept;
    logic respPush;
    logic adelPush;
    logic pop;
    logic aligned;
    logic creditOk;
    logic [DIS_W-1:0] discardRedir;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and per-cycle control decisions
    always_comb begin
        stateNext    = state;
        instReq      = 1'b0;
        adelPush     = 1'b0;
        aligned      = (fetchPc[1:0] == 2'b00);
        creditOk     = (inflight < INF_W'(MAX_OUTSTANDING))
                     && ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));
        case (state)
            RUN: begin
                instReq  = aligned && creditOk && !fq.redirect_valid && !rst;
                adelPush = !aligned && (inflight == '0) && (discard == '0)
                         && (count < CNT_W'(DEPTH)) && !fq.redirect_valid;
                if (adelPush) begin
                    stateNext = HALT;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
        if (fq.redirect_valid) begin
            stateNext = RUN;
        end
        accept       = instReq && fq.inst_addr_ok;
        respPush     = fq.inst_data_ok && (discard == '0) && !fq.redirect_valid;
        pop          = (count != '0) && fq.decode_ready && !fq.redirect_valid;
        // Every read still on the bus, old or new, becomes a word to drop
        discardRedir = discard + DIS_W'(inflight) + DIS_W'(accept) - DIS_W'(fq.inst_data_ok);
    end

    // PC, credit and FIFO datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc  <= RESET_PC;
            respPc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                memInstr[i] <= '0;
                memPc[i]    <= '0;
                memAdel[i]  <= 1'b0;
            end
        end else if (fq.redirect_valid) begin
            fetchPc  <= fq.redirect_pc;
            respPc   <= fq.redirect_pc;
            inflight <= '0;
            discard  <= discardRedir;
            count    <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
        end else begin
            if (accept) begin
                fetchPc <= fetchPc + 32'd4;
            end
            inflight <= inflight + INF_W'(accept) - INF_W'(respPush);
            if (fq.inst_data_ok && (discard != '0)) begin
                discard <= discard - DIS_W'(1);
            end
            if (respPush) begin
                memInstr[wrPtr] <= fq.inst_rdata;
                memPc[wrPtr]    <= respPc;
                memAdel[wrPtr]  <= 1'b0;
                respPc          <= respPc + 32'd4;
                wrPtr           <= wrPtr + PTR_W'(1);
            end else if (adelPush) begin
                memInstr[wrPtr] <= 32'h0;
                memPc[wrPtr]    <= fetchPc;
                memAdel[wrPtr]  <= 1'b1;
                wrPtr           <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(respPush || adelPush) - CNT_W'(pop);
        end
    end

    assign fq.inst_req     = instReq;
    assign fq.inst_addr    = fetchPc;
    assign fq.instrD_valid = (count != '0);
    assign fq.instrD       = memInstr[rdPtr];
    assign fq.pcD          = memPc[rdPtr];
    assign fq.adelD        = memAdel[rdPtr];
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized scoreboard bench for if_fetch_queue: a transaction-level model
// predicts requests and the decode stream; a separate monitor checks outputs.
module tb_if_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_queue_if bus();

    if_fetch_queue #(
        .DEPTH(DEPTH),
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC(32'hBFC00000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fq(bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } rd_t;

    int checks = 0;
    int errors = 0;

    exp_t expQ[$];
    rd_t  pend[$];
    logic [31:0] mPc;
    int   epoch;
    int   inflightCur;
    bit   halted;
    int   pAddr;
    int   pData;
    int   pReady;

    function automatic logic [31:0] wordOf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus/decoder cycle: drive, check request prediction, then advance the model at the edge
    task automatic step(input bit redir, input logic [31:0] rpc);
        bit   dOk;
        bit   expReq;
        bit   expAdel;
        bit   acc;
        rd_t  r;
        @(negedge clk);
        dOk = (pend.size() > 0) && ($urandom_range(99) < pData);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.inst_addr_ok   = ($urandom_range(99) < pAddr);
        bus.inst_data_ok   = dOk;
        bus.inst_rdata     = dOk ? wordOf(pend[0].addr) : $urandom;
        bus.decode_ready   = ($urandom_range(99) < pReady);
        #1;
        expReq  = !halted && (mPc[1:0] == 2'b00) && !redir && (inflightCur < int'(MAXO))
                && ((expQ.size() + inflightCur) < int'(DEPTH));
        expAdel = !halted && (mPc[1:0] != 2'b00) && !redir && (pend.size() == 0)
                && (expQ.size() < int'(DEPTH));
        check("inst_req", 32'(bus.inst_req), 32'(expReq));
        if (expReq) check("inst_addr", bus.inst_addr, mPc);
        acc = expReq && bus.inst_addr_ok;
        @(posedge clk);
        if (dOk) begin
            r = pend.pop_front();
            if (!redir && r.epoch == epoch) begin
                expQ.push_back('{wordOf(r.addr), r.addr, 1'b0});
                inflightCur--;
            end
        end
        if (acc) begin
            pend.push_back('{mPc, epoch});
            mPc = mPc + 32'd4;
            inflightCur++;
        end
        if (expAdel) begin
            expQ.push_back('{32'h0, mPc, 1'b1});
            halted = 1'b1;
        end
        if (redir) begin
            epoch++;
            inflightCur = 0;
            expQ.delete();
            mPc    = rpc;
            halted = 1'b0;
        end
    endtask

    // Monitor: compares the decode head whenever a handshake completes
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("instrD_valid", 32'(bus.instrD_valid), 32'(expQ.size() > 0));
                if (bus.instrD_valid && bus.decode_ready && !bus.redirect_valid && expQ.size() > 0) begin
                    e = expQ.pop_front();
                    check("instrD", bus.instrD, e.instr);
                    check("pcD", bus.pcD, e.pc);
                    check("adelD", 32'(bus.adelD), 32'(e.adel));
                end
            end
        end
    end

    initial begin
        logic [31:0] rpc;
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_addr_ok   = 1'b0;
        bus.inst_data_ok   = 1'b0;
        bus.inst_rdata     = 32'h0;
        bus.decode_ready   = 1'b0;
        mPc         = 32'hBFC00000;
        epoch       = 0;
        inflightCur = 0;
        halted      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst instrD_valid", 32'(bus.instrD_valid), 32'h0);
        check("rst instrD", bus.instrD, 32'h0);
        check("rst pcD", bus.pcD, 32'h0);
        check("rst adelD", 32'(bus.adelD), 32'h0);
        check("rst inst_req", 32'(bus.inst_req), 32'h0);
        check("rst inst_addr", bus.inst_addr, 32'hBFC00000);
        rst = 1'b0;

        // Streaming at full rate
        pAddr = 100; pData = 100; pReady = 100;
        repeat (30) step(1'b0, 32'h0);

        // Decoder stall fills the queue, then release
        pReady = 0;
        repeat (20) step(1'b0, 32'h0);
        pReady = 100;
        repeat (20) step(1'b0, 32'h0);

        // Two reads outstanding at redirect
        pData = 0;
        repeat (4) step(1'b0, 32'h0);
        pData = 100;
        step(1'b1, 32'h80000100);
        repeat (12) step(1'b0, 32'h0);

        // Misaligned redirect yields one AdEL marker, then silence
        step(1'b1, 32'h80000102);
        repeat (15) step(1'b0, 32'h0);
        step(1'b1, 32'h80000200);
        repeat (12) step(1'b0, 32'h0);

        // Redirect while data returns in the same cycle
        step(1'b1, 32'h80000300);
        repeat (12) step(1'b0, 32'h0);

        // Randomized traffic with periodic redirects, including misaligned and wrapping targets
        pAddr = 60; pData = 50; pReady = 70;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) begin
                rpc = $urandom & 32'hFFFFFFFC;
                if ($urandom_range(99) < 10) rpc = 32'hFFFFFFF0;
                if ($urandom_range(99) < 20) rpc = rpc | 32'(1 + $urandom_range(2));
                step(1'b1, rpc);
            end else begin
                step(1'b0, 32'h0);
            end
        end
        pAddr = 0; pData = 100; pReady = 100;
        repeat (20) step(1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
